// File: rtl/addsub_pipe_if.sv
// Stream interface for addsub_pipe: operand beats in, result beats out.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             ovf;

    modport master (
        output in_valid, a, b, sign, out_ready,
        input  in_ready, out_valid, s, ovf
    );

    modport slave (
        input  in_valid, a, b, sign, out_ready,
        output in_ready, out_valid, s, ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// Carry-segmented pipelined adder/subtractor.
// Stage k resolves SEG bits of the result using the carry registered by
// stage k-1, so the carry chain per cycle is only SEG bits long.
// All stages shift together when the output slot is free or being consumed.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic         clk,
    input  logic         rst,
    addsub_pipe_if.slave bus
);
    localparam int NSTG = WIDTH / SEG;

    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("addsub_pipe: WIDTH must lie in 4..64");
    end
    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_seg
        $error("addsub_pipe: WIDTH must be a multiple of SEG");
    end

    // One pipeline slot. Operands travel with the beat; bits below the
    // current segment are already folded into sum and are dead downstream.
    typedef struct packed {
        logic             valid;
        logic             sign;   // 1 = subtract
        logic             carry;  // carry into the next unresolved segment
        logic [WIDTH-1:0] sum;    // resolved low segments
        logic [WIDTH-1:0] a;      // operand a
        logic [WIDTH-1:0] bx;     // operand b, inverted when subtracting
    } stage_t;

    stage_t       stage_q [NSTG];
    stage_t       stage_d [NSTG];
    stage_t       src     [NSTG];
    logic         advance;
    logic [SEG:0] seg_sum;

    // Next-state for every stage: resolve one segment, or hold on stall.
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results (seg_sum is reused per stage); flops use '<='.
    always_comb begin
        advance = !stage_q[NSTG-1].valid || bus.out_ready;

        src[0].valid = bus.in_valid;
        src[0].sign  = bus.sign;
        src[0].carry = bus.sign;   // the +1 of a + ~b + 1
        src[0].sum   = '0;
        src[0].a     = bus.a;
        src[0].bx    = bus.sign ? ~bus.b : bus.b;
        for (int k = 1; k < NSTG; k++) begin
            src[k] = stage_q[k-1];
        end

        seg_sum = '0;
        for (int k = 0; k < NSTG; k++) begin
            seg_sum = {1'b0, src[k].a[k*SEG +: SEG]}
                    + {1'b0, src[k].bx[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, src[k].carry};
            stage_d[k]                   = src[k];
            stage_d[k].sum[k*SEG +: SEG] = seg_sum[SEG-1:0];
            stage_d[k].carry             = seg_sum[SEG];
            if (!advance) begin
                stage_d[k] = stage_q[k];
            end
        end
    end

    // Pipeline registers with synchronous reset.
    // NOTE: the datapath fields are reset too, not just valid, because the
    // result and overflow outputs are required to read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Outputs come straight from the last stage, so they hold while stalled.
    // For subtract the top bit is a borrow, i.e. the inverted carry-out.
    assign bus.in_ready  = advance;
    assign bus.out_valid = stage_q[NSTG-1].valid;
    assign bus.s         = {stage_q[NSTG-1].carry ^ stage_q[NSTG-1].sign,
                            stage_q[NSTG-1].sum};
    assign bus.ovf       = (stage_q[NSTG-1].a[WIDTH-1] == stage_q[NSTG-1].bx[WIDTH-1])
                        && (stage_q[NSTG-1].sum[WIDTH-1] != stage_q[NSTG-1].a[WIDTH-1]);
endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, SEG=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Accepted beats push a model result into a scoreboard.
module tb_addsub_pipe;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSTG  = WIDTH / SEG;

    typedef struct {
        logic [WIDTH:0] s;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

    addsub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference arithmetic, written from the unsigned/signed definitions.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub);
        exp_t           e;
        logic [WIDTH:0] full;
        if (!sub) begin
            full  = {1'b0, a} + {1'b0, b};
            e.s   = full;
            e.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        end else begin
            full  = {1'b0, a} - {1'b0, b};
            e.s   = {(a < b), full[WIDTH-1:0]};
            e.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(4, 0))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom());
        endcase
    endfunction

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.sign     = sub;
    endtask

    // Called at the falling edge: record a beat the coming edge accepts,
    // then move to just after that edge.
    task automatic tick();
        if (bus.in_valid && bus.in_ready && !rst) begin
            sb.push_back(model(bus.a, bus.b, bus.sign));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen;
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.s !== '0 || bus.ovf !== 1'b0)
            $display("FAIL reset_outputs: got valid=%b s=%h ovf=%b want 0/0/0",
                     bus.out_valid, bus.s, bus.ovf);
        else n_pass++;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 2 * NSTG; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL reset_discard: beat offered in reset emerged (got 1 want 0)");
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_idle_ready: got %b want 1", bus.in_ready);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_edge_ops();
        logic [WIDTH-1:0] va [4] = '{16'hFFFF, 16'h0003, 16'h8000, 16'h7FFF};
        logic [WIDTH-1:0] vb [4] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001};
        logic             vs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [WIDTH:0]   xs [4] = '{17'h10000, 17'h1FFFE, 17'h07FFF, 17'h08000};
        logic             xo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic             early;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            drive(1'b1, va[v], vb[v], vs[v]);
            @(negedge clk);
            tick();
            drive(1'b0, '0, '0, 1'b0);
            early = 1'b0;
            for (int i = 1; i < NSTG; i++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b0) early = 1'b1;
                tick();
            end
            @(negedge clk);
            n_total++;
            if (early !== 1'b0 || bus.out_valid !== 1'b1)
                $display("FAIL edge_latency_%0d: early=%b valid=%b want early=0 valid=1",
                         v, early, bus.out_valid);
            else n_pass++;
            n_total++;
            if (bus.s !== xs[v] || bus.ovf !== xo[v])
                $display("FAIL edge_result_%0d: got s=%h ovf=%b want s=%h ovf=%b",
                         v, bus.s, bus.ovf, xs[v], xo[v]);
            else n_pass++;
            tick();
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drive(1'b1, WIDTH'($urandom()), WIDTH'($urandom()), 1'($urandom_range(1, 0)));
            else       drive(1'b0, '0, '0, 1'b0);
            @(negedge clk);
            n_total++;
            if (bus.out_valid !== (c >= NSTG && c < NSTG + 8))
                $display("FAIL b2b_valid_c%0d: got %b want %b", c, bus.out_valid,
                         (c >= NSTG && c < NSTG + 8));
            else n_pass++;
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL b2b_extra: got s=%h want no result", bus.s);
                else begin
                    e = sb.pop_front();
                    if (bus.s !== e.s || bus.ovf !== e.ovf)
                        $display("FAIL b2b_data: got s=%h ovf=%b want s=%h ovf=%b",
                                 bus.s, bus.ovf, e.s, e.ovf);
                    else n_pass++;
                end
            end
            tick();
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL b2b_drain: %0d results missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t           e;
        int             accepted;
        logic           acc;
        logic           stable;
        logic           ready_ok;
        logic [WIDTH:0] hold_s;
        logic           hold_ovf;
        accepted      = 0;
        stable        = 1'b1;
        hold_s        = '0;
        hold_ovf      = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, pick(), pick(), 1'($urandom_range(1, 0)));
        for (int c = 0; c < 3 * NSTG; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) accepted++;
            if (c == NSTG) begin
                hold_s   = bus.s;
                hold_ovf = bus.ovf;
            end else if (c > NSTG && (bus.s !== hold_s || bus.ovf !== hold_ovf)) begin
                stable = 1'b0;
            end
            tick();
            if (acc) drive(1'b1, pick(), pick(), 1'($urandom_range(1, 0)));
        end
        @(negedge clk);
        n_total++;
        if (accepted != NSTG) $display("FAIL bp_capacity: accepted %0d want %0d", accepted, NSTG);
        else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", bus.in_ready, bus.out_valid);
        else n_pass++;
        n_total++;
        if (stable !== 1'b1) $display("FAIL bp_stable: output changed while stalled (got 0 want 1)");
        else n_pass++;
        tick();
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        ready_ok = 1'b1;
        for (int c = 0; c < 2 * NSTG; c++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1) ready_ok = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL bp_extra: got s=%h want no result", bus.s);
                else begin
                    e = sb.pop_front();
                    if (bus.s !== e.s || bus.ovf !== e.ovf)
                        $display("FAIL bp_data: got s=%h ovf=%b want s=%h ovf=%b",
                                 bus.s, bus.ovf, e.s, e.ovf);
                    else n_pass++;
                end
            end
            tick();
        end
        n_total++;
        if (ready_ok !== 1'b1) $display("FAIL bp_drain_ready: in_ready dropped (got 0 want 1)");
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL bp_drain: %0d results missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, pick(), pick(), 1'($urandom_range(1, 0)));
            @(negedge clk);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        sb.delete();
        drive(1'b1, 16'h1357, 16'h2468, 1'b1);
        for (int c = 0; c < 2 * NSTG + 2; c++) begin
            @(negedge clk);
            n_total++;
            if (c == 0) begin
                if (bus.out_valid !== 1'b0) $display("FAIL mrst_clear: valid=%b want 0", bus.out_valid);
                else n_pass++;
            end else begin
                if (bus.out_valid !== (c == NSTG))
                    $display("FAIL mrst_latency_c%0d: got %b want %b", c, bus.out_valid, (c == NSTG));
                else n_pass++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL mrst_stale: got s=%h want no result", bus.s);
                else begin
                    e = sb.pop_front();
                    if (bus.s !== e.s || bus.ovf !== e.ovf)
                        $display("FAIL mrst_data: got s=%h ovf=%b want s=%h ovf=%b",
                                 bus.s, bus.ovf, e.s, e.ovf);
                    else n_pass++;
                end
            end
            tick();
            if (c == 0) drive(1'b0, '0, '0, 1'b0);
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL mrst_lost: %0d results missing, want 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        int   beats;
        int   cyc;
        beats = 0;
        cyc   = 0;
        sb.delete();
        while (beats < 10000 && cyc < 60000) begin
            drive($urandom_range(3, 0) != 0, pick(), pick(), 1'($urandom_range(1, 0)));
            bus.out_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) beats++;
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL rand_extra: got s=%h want no result", bus.s);
                else begin
                    e = sb.pop_front();
                    if (bus.s !== e.s || bus.ovf !== e.ovf)
                        $display("FAIL rand_data: got s=%h ovf=%b want s=%h ovf=%b",
                                 bus.s, bus.ovf, e.s, e.ovf);
                    else n_pass++;
                end
            end
            tick();
            cyc++;
        end
        n_total++;
        if (beats < 10000) $display("FAIL rand_budget: accepted %0d beats want 10000", beats);
        else n_pass++;
        drive(1'b0, '0, '0, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2 * NSTG; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL rand_extra: got s=%h want no result", bus.s);
                else begin
                    e = sb.pop_front();
                    if (bus.s !== e.s || bus.ovf !== e.ovf)
                        $display("FAIL rand_data: got s=%h ovf=%b want s=%h ovf=%b",
                                 bus.s, bus.ovf, e.s, e.ovf);
                    else n_pass++;
                end
            end
            tick();
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL rand_lost: %0d results missing, want 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        test_reset();
        test_edge_ops();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
